crossword_timer: RTL

- Parametrised mm:ss puzzle timer for the crossword game: counts up as a stopwatch, or down from a loaded preset as a countdown.
- Adds start/stop/pause, preset load, lap capture, an expiry pulse and a wrap pulse.
- Sits between the game-control FSM (commands in) and the seven-segment hex drivers (4-bit BCD digits out).

---
 rtl/crossword_timer.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/crossword_timer.sv
// Puzzle timer for the crossword game: mm:ss stopwatch (up-count) or
// countdown from a loaded preset, with pause/resume, lap capture and
// expiry / wrap / load-error pulses.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start, stop       single-cycle pulses: begin/resume, pause
//   clear, load       single-cycle pulses: zero and go idle, load preset
//   count_down        1 = down-count, 0 = up-count (sampled at each tick)
//   load_digits[15:0] BCD preset {tens_min, min, tens_sec, sec}
//   lap               single-cycle pulse: capture current time
//   digits[15:0]      live BCD time
//   lap_digits[15:0]  last captured BCD time
//   running           high while counting
//   expired           one-cycle pulse when the countdown hits 00:00
//   wrapped           one-cycle pulse when the up-count rolls over
//   load_err          one-cycle pulse when a preset is rejected
module crossword_timer #(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned MAX_TENS_MIN = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        load,
  input  logic        count_down,
  input  logic [15:0] load_digits,
  input  logic        lap,
  output logic [15:0] digits,
  output logic [15:0] lap_digits,
  output logic        running,
  output logic        expired,
  output logic        wrapped,
  output logic        load_err
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [3:0]    TM_MAX    = 4'(MAX_TENS_MIN);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [15:0]   digits_nxt, lap_nxt;
  logic          running_nxt, expired_nxt, wrapped_nxt, load_err_nxt;
  logic          tick_c;

  logic [3:0]  sec_d, tsec_d, min_d, tmin_d;
  logic [15:0] up_val, dn_val;
  logic        up_wrap, dn_zero;
  logic        load_ok;

  assign {tmin_d, min_d, tsec_d, sec_d} = digits;

  // One-second strobe, only meaningful while running
  assign tick_c = (state == ST_RUN) && (presc == PRESC_MAX);

  // Preset must be a legal time for this timer's range
  assign load_ok = (load_digits[3:0]   <= 4'd9) &&
                   (load_digits[7:4]   <= 4'd5) &&
                   (load_digits[11:8]  <= 4'd9) &&
                   (load_digits[15:12] <= TM_MAX);

  // Up-count carry chain; rolls over to 00:00 after MAX_TENS_MIN 9:59
  always_comb begin
    up_val  = digits;
    up_wrap = 1'b0;
    if (sec_d < 4'd9) begin
      up_val[3:0] = sec_d + 4'd1;
    end else begin
      up_val[3:0] = 4'd0;
      if (tsec_d < 4'd5) begin
        up_val[7:4] = tsec_d + 4'd1;
      end else begin
        up_val[7:4] = 4'd0;
        if (min_d < 4'd9) begin
          up_val[11:8] = min_d + 4'd1;
        end else begin
          up_val[11:8] = 4'd0;
          if (tmin_d < TM_MAX) begin
            up_val[15:12] = tmin_d + 4'd1;
          end else begin
            up_val[15:12] = 4'd0;
            up_wrap       = 1'b1;
          end
        end
      end
    end
  end

  // Down-count borrow chain; saturates at 00:00 (never underflows)
  always_comb begin
    dn_val = digits;
    if (digits != 16'h0000) begin
      if (sec_d != 4'd0) begin
        dn_val[3:0] = sec_d - 4'd1;
      end else begin
        dn_val[3:0] = 4'd9;
        if (tsec_d != 4'd0) begin
          dn_val[7:4] = tsec_d - 4'd1;
        end else begin
          dn_val[7:4] = 4'd5;
          if (min_d != 4'd0) begin
            dn_val[11:8] = min_d - 4'd1;
          end else begin
            dn_val[11:8]  = 4'd9;
            dn_val[15:12] = tmin_d - 4'd1;
          end
        end
      end
    end
  end

  assign dn_zero = (dn_val == 16'h0000);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath. Within a cycle only the highest-priority
  // command that actually applies to the current state takes effect:
  // clear > load > stop > start > tick. Commands that mean nothing in the
  // current state (load/start while running, stop while not running) do
  // not suppress lower-priority ones.
  always_comb begin
    state_nxt    = state;
    presc_nxt    = presc;
    digits_nxt   = digits;
    lap_nxt      = lap_digits;
    expired_nxt  = 1'b0;
    wrapped_nxt  = 1'b0;
    load_err_nxt = 1'b0;

    if (clear) begin
      state_nxt  = ST_IDLE;
      presc_nxt  = '0;
      digits_nxt = 16'h0000;
      lap_nxt    = 16'h0000;
    end else begin
      // Lap captures the value before any same-cycle tick update
      if (lap && (state == ST_RUN || state == ST_PAUSED)) begin
        lap_nxt = digits;
      end

      case (state)
        ST_RUN: begin
          if (stop) begin
            // Prescaler holds so resume finishes the partial second
            state_nxt = ST_PAUSED;
          end else if (tick_c) begin
            presc_nxt = '0;
            if (count_down) begin
              digits_nxt = dn_val;
              if (dn_zero) begin
                expired_nxt = 1'b1;
                state_nxt   = ST_EXPIRED;
              end
            end else begin
              digits_nxt  = up_val;
              wrapped_nxt = up_wrap;
            end
          end else begin
            presc_nxt = presc + PW'(1);
          end
        end

        ST_IDLE, ST_PAUSED, ST_EXPIRED: begin
          if (load) begin
            if (load_ok) begin
              digits_nxt = load_digits;
              state_nxt  = ST_IDLE;
              presc_nxt  = '0;
            end else begin
              load_err_nxt = 1'b1;
            end
          end else if (start && state != ST_EXPIRED) begin
            state_nxt = ST_RUN;
            // A fresh start begins a whole second; resume keeps the fraction
            if (state == ST_IDLE) begin
              presc_nxt = '0;
            end
          end
        end

        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end

    running_nxt = (state_nxt == ST_RUN);
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc      <= '0;
      digits     <= 16'h0000;
      lap_digits <= 16'h0000;
      running    <= 1'b0;
      expired    <= 1'b0;
      wrapped    <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      presc      <= presc_nxt;
      digits     <= digits_nxt;
      lap_digits <= lap_nxt;
      running    <= running_nxt;
      expired    <= expired_nxt;
      wrapped    <= wrapped_nxt;
      load_err   <= load_err_nxt;
    end
  end

endmodule
